banked_scratchpad_xbar: RTL and testbench
=========================================

Name: banked_scratchpad_xbar

Overview:
Multi-port, address-interleaved banked scratchpad. NUM_PORTS requesters share NUM_BANKS single-access banks through a request crossbar with per-bank round-robin arbitration.
Generalises the fixed one-port-per-bank scratchpad: any port can reach any bank, bank conflicts are resolved in hardware, and read data is returned to the requesting port with a fixed latency.
Sits between the compute/DMA engines and on-chip buffer storage.

Parameters:
DATA_WIDTH, 16, word width in bits.
ADDR_WIDTH, 13, global word address width. The low log2(NUM_BANKS) bits select the bank; the rest form the bank row.
NUM_BANKS, 8, bank count. Must be a power of 2, ≥2.
NUM_PORTS, 4, requester port count, ≥1.
CNT_WIDTH, 32, width of the conflict counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_PORTS  per-port request valid
we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
addr  in  NUM_PORTS*ADDR_WIDTH  per-port global word address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
gnt  out  NUM_PORTS  per-port grant (combinational)
rvalid  out  NUM_PORTS  per-port read-data valid
rdata  out  NUM_PORTS*DATA_WIDTH  per-port read data
conflict_cnt  out  CNT_WIDTH  saturating count of port-cycles with req=1 and gnt=0

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset.
- Reset values: rvalid=0, rdata=0, conflict_cnt=0, all round-robin pointers=0. Memory contents are not reset.
- Address mapping: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[ADDR_WIDTH-1:log2(NUM_BANKS)]. Each bank holds 2^(ADDR_WIDTH-log2(NUM_BANKS)) words.
- Each bank performs at most one access (read or write) per cycle.
- Arbitration is per bank, round-robin among ports whose req=1 and target that bank.
  - Search starts at the bank's pointer ptr[b].
  - On a grant to port p, ptr[b] <= (p+1) mod NUM_PORTS. The pointer is unchanged when the bank has no requester.
  - gnt is combinational from req/addr and the registered pointers. No combinational path from gnt back to req.
- Handshake: a transfer occurs when req & gnt. A port that sees gnt=0 must hold req, we, addr and wdata stable. Dropping req before grant is permitted; the pending request is discarded.
- Write granted in cycle T: the bank row is updated at the clk edge ending T.
- Read granted in cycle T:
  - rvalid[p]=1 and rdata[p] = bank word in cycle T+1, i.e. 1-cycle latency, registered output.
  - rvalid[p]=0 in cycles with no granted read. rdata holds its last value.
- Read-after-write, same address, write in T and read granted in T+1: the read returns the new data. Write and read to the same address cannot both be granted in one cycle (same bank).
- Full throughput: all ports targeting distinct banks are all granted in the same cycle. Back-to-back reads from one port produce rvalid on consecutive cycles.
- conflict_cnt increments each cycle by popcount(req & ~gnt) and saturates at all-ones (no wrap).
- Reset asserted mid-operation:
  - In-flight read results are dropped; rvalid=0 in the cycle after reset.
  - Grants are not issued while reset=1 (gnt=0).
  - Writes presented during the reset cycle are not performed.
- Out-of-range parameters (NUM_BANKS not a power of 2) are flagged by an elaboration-time check.

Decomposition:
- Package banked_scratchpad_pkg holds:
  - bank-index width function clog2;
  - localparams BANK_SEL_W = clog2(NUM_BANKS) and ROW_W = ADDR_WIDTH - BANK_SEL_W;
  - port/bank slice helper functions.
- One sub-module, rr_arbiter (parameter N = NUM_PORTS). Inputs: request vector and clk/reset. Outputs: one-hot grant and encoded index. Holds the internal pointer. It is instantiated once per bank.
- Bank storage reuses the existing scratchpad module, one instance per bank.
- Read-return routing uses a registered per-port {valid, bank index} to select the bank output in T+1.

Test Plan:
- Reset, then port0 writes 0xBEEF to addr 0x005 and port1 reads 0x005 the next cycle -> gnt=1 for both; rvalid[1]=1 with rdata[1]=0xBEEF one cycle after the read grant.
- 4 ports read addrs 0x000, 0x001, 0x002, 0x003 (distinct banks) in the same cycle -> gnt=4'b1111; all rvalid=1 the next cycle; conflict_cnt stays 0.
- 4 ports read addr 0x008, 0x010, 0x018, 0x020 (all bank 0), each holding req until granted -> one grant per cycle in order 0,1,2,3; conflict_cnt=3+2+1=6 after 4 cycles.
- Ports 0 and 2 continuously hit bank 3 for 6 cycles -> grants alternate 0,2,0,2,0,2; each port receives 3 rvalid pulses.
- Assert reset for 1 cycle while a read is granted -> rvalid=0 the following cycle; conflict_cnt=0; the next grant starts from port 0.
- Force conflict_cnt near saturation with CNT_WIDTH=4 and keep conflicting -> counter holds at 4'hF and does not wrap.

Source files
------------

// File: rtl/banked_scratchpad_pkg.sv
// Shared helpers for the banked scratchpad crossbar.
// Index-width math and per-port bus slicing.
package banked_scratchpad_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Low bit of element idx in a flat bus of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    localparam int DEF_NUM_BANKS  = 8;
    localparam int DEF_ADDR_WIDTH = 13;
    localparam int BANK_SEL_W     = clog2(DEF_NUM_BANKS);
    localparam int ROW_W          = DEF_ADDR_WIDTH - BANK_SEL_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one per bank.
// Search starts at ptr; ptr moves past the winner.
module rr_arbiter
    import banked_scratchpad_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            c;

    // First requester at or after ptr wins; nothing during reset.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && !reset && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

    // Pointer advances only when a grant is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/scratchpad.sv
// Single-port bank storage: one read or write per cycle.
// Read data is registered and holds until the next read.
module scratchpad #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_W      = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      row,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ROW_W];

    // One access per cycle; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[row] <= wdata;
            else    rdata    <= mem[row];
        end
    end

endmodule

// File: rtl/banked_scratchpad_xbar.sv
// Multi-port interleaved scratchpad with per-bank
// round-robin crossbar and 1-cycle read return.
module banked_scratchpad_xbar
    import banked_scratchpad_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_BANKS  = 8,
    parameter int NUM_PORTS  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]            conflict_cnt
);

    localparam int SEL_W = clog2(NUM_BANKS);
    localparam int RW    = ADDR_WIDTH - SEL_W;
    localparam int IW    = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    if (!is_pow2(NUM_BANKS) || NUM_BANKS < 2) begin : g_bad_banks
        $error("NUM_BANKS must be a power of 2 and >= 2");
    end

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] bank;
    } rtn_t;

    logic [NUM_PORTS-1:0][SEL_W-1:0]      pbank;
    logic [NUM_PORTS-1:0][RW-1:0]         prow;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] pwd;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  breq;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bgnt;
    logic [NUM_BANKS-1:0][IW-1:0]         bidx;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bdout;
    rtn_t [NUM_PORTS-1:0]                 rtn_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_mux;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_hold;
    logic [CNT_WIDTH-1:0]                 cnt_q;
    logic [CNT_WIDTH:0]                   n_conf;
    logic [CNT_WIDTH:0]                   cnt_sum;

    // Split each port's address into bank select and row.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pbank[p] = addr[slice_lo(p, ADDR_WIDTH) +: SEL_W];
            prow[p]  = addr[slice_lo(p, ADDR_WIDTH) + SEL_W +: RW];
            pwd[p]   = wdata[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    // Route each port request to the bank it addresses.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                breq[b][p] = req[p] && (pbank[p] == SEL_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (breq[b]),
            .gnt   (bgnt[b]),
            .idx   (bidx[b])
        );

        scratchpad #(.DATA_WIDTH(DATA_WIDTH), .ROW_W(RW)) u_mem (
            .clk   (clk),
            .en    (|bgnt[b]),
            .we    (we[bidx[b]]),
            .row   (prow[bidx[b]]),
            .wdata (pwd[bidx[b]]),
            .rdata (bdout[b])
        );
    end

    // A port targets one bank, so OR-ing bank grants is exact.
    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) gnt = gnt | bgnt[b];
    end

    // Remember which bank will hold each port's read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rtn_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rtn_q[p].valid <= gnt[p] & ~we[p];
                if (gnt[p]) rtn_q[p].bank <= pbank[p];
            end
        end
    end

    // Pick the bank output on return, otherwise keep the last word.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_mux[p] = rtn_q[p].valid ? bdout[rtn_q[p].bank] : rd_hold[p];
            rdata[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = rd_mux[p];
            rvalid[p] = rtn_q[p].valid;
        end
    end

    // Hold register so rdata survives idle cycles.
    always_ff @(posedge clk) begin
        if (reset) rd_hold <= '0;
        else       rd_hold <= rd_mux;
    end

    // Count requesters left waiting this cycle.
    always_comb begin
        n_conf = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_conf = n_conf + {{CNT_WIDTH{1'b0}}, req[p] & ~gnt[p]};
        end
        cnt_sum = {1'b0, cnt_q} + n_conf;
    end

    // Saturating conflict counter.
    always_ff @(posedge clk) begin
        if (reset)                 cnt_q <= '0;
        else if (cnt_sum[CNT_WIDTH]) cnt_q <= '1;
        else                       cnt_q <= cnt_sum[CNT_WIDTH-1:0];
    end

    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_banked_scratchpad_xbar.sv
// Randomised and directed bench for banked_scratchpad_xbar.
// Reference model: address-keyed memory + per-bank RR pointers.
module tb_banked_scratchpad_xbar;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int NB = 8;
    localparam int NP = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req, we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    gnt, rvalid, gnt4, rvalid4;
    logic [NP*DW-1:0] rdata, rdata4;
    logic [31:0]      cnt;
    logic [3:0]       cnt4;

    banked_scratchpad_xbar dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .conflict_cnt(cnt)
    );

    banked_scratchpad_xbar #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
        .conflict_cnt(cnt4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          t_reset;
    bit          t_req [NP];
    bit          t_we  [NP];
    int          t_addr[NP];
    logic [15:0] t_wd  [NP];

    int          ptr [NB];
    logic [15:0] mem [int];
    logic [NP-1:0] exp_gnt, obs_gnt, obs_gnt4;
    bit          exp_rv [NP];
    logic [15:0] exp_rd [NP];
    bit          exp_rk [NP];
    longint      m_cnt;
    int          m_cnt4;

    function automatic logic [15:0] rd_of(input int p);
        logic [NP*DW-1:0] v;
        v = rdata;
        return v[p*DW +: DW];
    endfunction

    task automatic apply();
        reset = t_reset;
        for (int p = 0; p < NP; p++) begin
            req[p] = t_req[p];
            we[p]  = t_we[p];
            addr[p*AW +: AW] = AW'(t_addr[p]);
            wdata[p*DW +: DW] = t_wd[p];
        end
    endtask

    task automatic model_arb();
        exp_gnt = '0;
        if (!t_reset) begin
            for (int b = 0; b < NB; b++) begin
                bit done = 0;
                for (int k = 0; k < NP; k++) begin
                    int p = (ptr[b] + k) % NP;
                    if (!done && t_req[p] && (t_addr[p] % NB) == b) begin
                        exp_gnt[p] = 1'b1;
                        done = 1;
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        int n = 0;
        if (t_reset) begin
            for (int b = 0; b < NB; b++) ptr[b] = 0;
            for (int p = 0; p < NP; p++) begin
                exp_rv[p] = 0; exp_rd[p] = '0; exp_rk[p] = 1;
            end
            m_cnt = 0; m_cnt4 = 0;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            if (t_req[p] && !exp_gnt[p]) n++;
            exp_rv[p] = exp_gnt[p] && !t_we[p];
            if (exp_rv[p]) begin
                exp_rk[p] = mem.exists(t_addr[p]);
                if (exp_rk[p]) exp_rd[p] = mem[t_addr[p]];
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_gnt[p]) begin
                if (t_we[p]) mem[t_addr[p]] = t_wd[p];
                ptr[t_addr[p] % NB] = (p + 1) % NP;
            end
        end
        m_cnt  = (m_cnt + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + n;
        m_cnt4 = (m_cnt4 + n > 15) ? 15 : m_cnt4 + n;
    endtask

    task automatic tick();
        apply();
        #1;
        model_arb();
        obs_gnt  = gnt;
        obs_gnt4 = gnt4;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) begin
            t_req[p] = 0; t_we[p] = 0; t_addr[p] = 0; t_wd[p] = '0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        t_reset = 1;
        tick();
        t_reset = 0;
    endtask

    task automatic test_reset();
        idle_all();
        t_reset = 1;
        for (int p = 0; p < NP; p++) begin
            t_req[p] = 1; t_addr[p] = p;
        end
        tick();
        checks++;
        if (obs_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b want 0000", obs_gnt);
        end
        tick();
        t_reset = 0;
        idle_all();
        checks++;
        if (rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rvalid got %b want 0000", rvalid);
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
        checks++;
        if (cnt !== 32'd0 || cnt4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt, cnt4);
        end
    endtask

    task automatic test_raw();
        do_reset();
        t_req[0] = 1; t_we[0] = 1; t_addr[0] = 5; t_wd[0] = 16'hBEEF;
        tick();
        checks++;
        if (obs_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL raw_wr_gnt got %b want 1", obs_gnt[0]);
        end
        idle_all();
        t_req[1] = 1; t_addr[1] = 5;
        tick();
        checks++;
        if (obs_gnt[1] !== 1'b1) begin
            errors++;
            $display("FAIL raw_rd_gnt got %b want 1", obs_gnt[1]);
        end
        idle_all();
        checks++;
        if (rvalid[1] !== 1'b1 || rd_of(1) !== 16'hBEEF) begin
            errors++;
            $display("FAIL raw_data got v=%b d=%h want v=1 d=beef",
                     rvalid[1], rd_of(1));
        end
        tick();
        checks++;
        if (rvalid[1] !== 1'b0 || rd_of(1) !== 16'hBEEF) begin
            errors++;
            $display("FAIL raw_hold got v=%b d=%h want v=0 d=beef",
                     rvalid[1], rd_of(1));
        end
    endtask

    task automatic test_full_throughput();
        logic [15:0] vals [NP];
        do_reset();
        for (int p = 0; p < NP; p++) begin
            vals[p] = 16'(16'h1100 * (p + 1) + p);
            t_req[p] = 1; t_we[p] = 1; t_addr[p] = p; t_wd[p] = vals[p];
        end
        tick();
        checks++;
        if (obs_gnt !== 4'b1111) begin
            errors++;
            $display("FAIL full_wr_gnt got %b want 1111", obs_gnt);
        end
        for (int p = 0; p < NP; p++) t_we[p] = 0;
        tick();
        checks++;
        if (obs_gnt !== 4'b1111 || rvalid !== 4'b1111) begin
            errors++;
            $display("FAIL full_rd got gnt=%b rv=%b want 1111/1111",
                     obs_gnt, rvalid);
        end
        idle_all();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (rd_of(p) !== vals[p]) begin
                errors++;
                $display("FAIL full_data p%0d got %h want %h",
                         p, rd_of(p), vals[p]);
            end
        end
        checks++;
        if (cnt !== 32'd0) begin
            errors++;
            $display("FAIL full_cnt got %0d want 0", cnt);
        end
    endtask

    task automatic test_bank_conflict();
        do_reset();
        for (int p = 0; p < NP; p++) begin
            t_req[p] = 1; t_addr[p] = 8 * (p + 1);
        end
        for (int i = 0; i < NP; i++) begin
            tick();
            checks++;
            if (obs_gnt !== 4'(1 << i)) begin
                errors++;
                $display("FAIL conflict_gnt cyc%0d got %b want %b",
                         i, obs_gnt, 4'(1 << i));
            end
            checks++;
            if (rvalid !== 4'(1 << i)) begin
                errors++;
                $display("FAIL conflict_rv cyc%0d got %b want %b",
                         i, rvalid, 4'(1 << i));
            end
            t_req[i] = 0;
        end
        checks++;
        if (cnt !== 32'd6) begin
            errors++;
            $display("FAIL conflict_cnt got %0d want 6", cnt);
        end
    endtask

    task automatic test_alternate();
        int pulses0 = 0;
        int pulses2 = 0;
        do_reset();
        t_req[0] = 1; t_addr[0] = 3;
        t_req[2] = 1; t_addr[2] = 11;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle_all();
            tick();
            if (i < 6) begin
                checks++;
                if (obs_gnt !== ((i % 2) ? 4'b0100 : 4'b0001)) begin
                    errors++;
                    $display("FAIL alt_gnt cyc%0d got %b", i, obs_gnt);
                end
            end
            pulses0 += int'(rvalid[0]);
            pulses2 += int'(rvalid[2]);
        end
        checks++;
        if (pulses0 != 3 || pulses2 != 3) begin
            errors++;
            $display("FAIL alt_pulses got %0d/%0d want 3/3",
                     pulses0, pulses2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        t_req[0] = 1; t_we[0] = 1; t_addr[0] = 64; t_wd[0] = 16'h5555;
        tick();
        idle_all();
        t_req[2] = 1; t_addr[2] = 8;
        tick();
        checks++;
        if (obs_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre_gnt got %b want 0100", obs_gnt);
        end
        t_reset = 1;
        t_req[0] = 1; t_we[0] = 1; t_addr[0] = 64; t_wd[0] = 16'h1234;
        tick();
        t_reset = 0;
        checks++;
        if (obs_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_gnt got %b want 0000", obs_gnt);
        end
        checks++;
        if (rvalid !== 4'b0000 || cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_after got rv=%b cnt=%0d want 0000/0",
                     rvalid, cnt);
        end
        idle_all();
        for (int p = 0; p < NP; p++) t_req[p] = 1;
        t_addr[0] = 64; t_addr[1] = 8; t_addr[2] = 16; t_addr[3] = 24;
        tick();
        idle_all();
        checks++;
        if (obs_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart_gnt got %b want 0001", obs_gnt);
        end
        checks++;
        if (rvalid[0] !== 1'b1 || rd_of(0) !== 16'h5555) begin
            errors++;
            $display("FAIL mid_nowrite got v=%b d=%h want v=1 d=5555",
                     rvalid[0], rd_of(0));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < NP; p++) begin
            t_req[p] = 1; t_addr[p] = 16 * p;
        end
        for (int i = 1; i <= 8; i++) begin
            int want4 = (3 * i > 15) ? 15 : 3 * i;
            tick();
            checks++;
            if (cnt4 !== 4'(want4) || cnt !== 32'(3 * i)) begin
                errors++;
                $display("FAIL sat_cnt cyc%0d got %0d/%0d want %0d/%0d",
                         i, cnt4, cnt, want4, 3 * i);
            end
        end
        idle_all();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            t_reset = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if (obs_gnt !== exp_gnt || obs_gnt4 !== exp_gnt) begin
                errors++;
                $display("FAIL rnd_gnt cyc%0d got %b/%b want %b",
                         c, obs_gnt, obs_gnt4, exp_gnt);
            end
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (rvalid[p] !== exp_rv[p]) begin
                    errors++;
                    $display("FAIL rnd_rv cyc%0d p%0d got %b want %b",
                             c, p, rvalid[p], exp_rv[p]);
                end
                if (exp_rk[p]) begin
                    checks++;
                    if (rd_of(p) !== exp_rd[p]) begin
                        errors++;
                        $display("FAIL rnd_rd cyc%0d p%0d got %h want %h",
                                 c, p, rd_of(p), exp_rd[p]);
                    end
                end
            end
            checks++;
            if (cnt !== 32'(m_cnt) || cnt4 !== 4'(m_cnt4)) begin
                errors++;
                $display("FAIL rnd_cnt cyc%0d got %0d/%0d want %0d/%0d",
                         c, cnt, cnt4, m_cnt, m_cnt4);
            end
            for (int p = 0; p < NP; p++) begin
                if (exp_gnt[p] || !t_req[p] || t_reset) begin
                    t_req[p]  = ($urandom_range(0, 9) < 7);
                    t_we[p]   = ($urandom_range(0, 2) == 0);
                    t_addr[p] = $urandom_range(0, 31);
                    t_wd[p]   = 16'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    t_req[p] = 0;
                end
            end
        end
        t_reset = 0;
        idle_all();
    endtask

    initial begin
        t_reset = 1;
        idle_all();
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        for (int p = 0; p < NP; p++) begin
            exp_rv[p] = 0; exp_rd[p] = '0; exp_rk[p] = 0;
        end
        m_cnt = 0; m_cnt4 = 0;
        apply();
        test_reset();
        test_raw();
        test_full_throughput();
        test_bank_conflict();
        test_alternate();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
